// File: rtl/host_rx_frame_if.sv
// Bundle between the host RX frame parser and its surroundings.
//   fifo_empty / fifo_dout / fifo_rd_en : RX FIFO pop port. Data is valid the
//                                         cycle after fifo_rd_en.
//   frm_valid / frm_ready / frm_*       : decoded frame output.
//   frm_err / frm_err_code              : dropped-frame report.
// Handshake: a frame transfers on any rising clk edge where frm_valid and
// frm_ready are both high. Once frm_valid rises, it and every frm_* field stay
// constant until that transfer. frm_ready may change freely.
// Modports: master = parser side, slave = FIFO/consumer side.
interface host_rx_frame_if #(
  parameter int MAX_LEN = 4
);
  logic                 fifo_empty;
  logic [7:0]           fifo_dout;
  logic                 fifo_rd_en;
  logic                 frm_valid;
  logic                 frm_ready;
  logic [7:0]           frm_cmd;
  logic [7:0]           frm_addr;
  logic [4:0]           frm_len;
  logic [8*MAX_LEN-1:0] frm_data;
  logic                 frm_err;
  logic [1:0]           frm_err_code;

  modport master (
    input  fifo_empty, fifo_dout, frm_ready,
    output fifo_rd_en, frm_valid, frm_cmd, frm_addr, frm_len, frm_data,
           frm_err, frm_err_code
  );

  modport slave (
    output fifo_empty, fifo_dout, frm_ready,
    input  fifo_rd_en, frm_valid, frm_cmd, frm_addr, frm_len, frm_data,
           frm_err, frm_err_code
  );
endinterface

// File: rtl/host_rx_frame_parser.sv
// Host RX frame parser. Pops bytes from the UART RX FIFO and assembles frames
// of the form SOF CMD ADDR LEN payload[LEN] CHK, where CHK is the XOR of
// CMD, ADDR, LEN and the payload. A good frame is held on frm_valid until
// accepted. A frame with a bad checksum, an oversize LEN or a mid-frame stall
// is dropped with a one-cycle frm_err pulse and a code (1/2/3).
// Ports:
//   clk       : clock, rising edge
//   reset_n   : synchronous active-low reset
//   bus       : host_rx_frame_if master (FIFO pop port + frame output)
//   dbg_state : current parser state, for observation only
module host_rx_frame_parser #(
  parameter logic [7:0] SOF_BYTE    = 8'hA5,
  parameter int         MAX_LEN     = 4,
  parameter int         TIMEOUT_CYC = 100000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  host_rx_frame_if.master        bus,
  output logic [2:0]             dbg_state
);
  typedef enum logic [2:0] {
    ST_SOF  = 3'd0,
    ST_CMD  = 3'd1,
    ST_ADDR = 3'd2,
    ST_LEN  = 3'd3,
    ST_DATA = 3'd4,
    ST_CHK  = 3'd5,
    ST_OUT  = 3'd6
  } state_e;

  localparam int               TMO_W     = $clog2(TIMEOUT_CYC + 1);
  localparam int               IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);

  state_e               state_q, state_d;
  logic                 byte_vld_q;
  logic [7:0]           chk_q, chk_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic [7:0]           cmd_q, cmd_d;
  logic [7:0]           addr_q, addr_d;
  logic [4:0]           len_q, len_d;
  logic [8*MAX_LEN-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;
  logic [1:0]           code_q, code_d;
  logic                 rd_en;
  logic                 in_frame;
  logic [7:0]           rx_byte;

  // One pop in flight at most: the pop cycle and its data cycle alternate,
  // so the peak rate is one byte every two clocks. ST_OUT blocks pops, which
  // keeps the FIFO untouched while a decoded frame waits for the consumer.
  assign rd_en   = reset_n && !bus.fifo_empty && !byte_vld_q && (state_q != ST_OUT);
  assign rx_byte = bus.fifo_dout;

  assign bus.fifo_rd_en   = rd_en;
  assign bus.frm_valid    = valid_q;
  assign bus.frm_cmd      = cmd_q;
  assign bus.frm_addr     = addr_q;
  assign bus.frm_len      = len_q;
  assign bus.frm_data     = data_q;
  assign bus.frm_err      = err_q;
  assign bus.frm_err_code = code_q;
  assign dbg_state        = state_q;

  always_comb begin
    state_d  = state_q;
    chk_d    = chk_q;
    idx_d    = idx_q;
    cmd_d    = cmd_q;
    addr_d   = addr_q;
    len_d    = len_q;
    data_d   = data_q;
    valid_d  = valid_q;
    err_d    = 1'b0;
    code_d   = code_q;
    in_frame = (state_q != ST_SOF) && (state_q != ST_OUT);

    // Idle-cycle counter: every byte (and so every state entry) clears it.
    tmo_d = '0;
    if (in_frame && !byte_vld_q) tmo_d = tmo_q + 1'b1;

    if (in_frame && (tmo_q == TMO_LAST)) begin
      // Expiry beats a byte arriving in the same cycle; that byte is lost.
      err_d   = 1'b1;
      code_d  = 2'd3;
      state_d = ST_SOF;
      tmo_d   = '0;
    end else if (state_q == ST_OUT) begin
      if (valid_q && bus.frm_ready) begin
        valid_d = 1'b0;
        state_d = ST_SOF;
      end
    end else if (byte_vld_q) begin
      case (state_q)
        ST_SOF: begin
          if (rx_byte == SOF_BYTE) begin
            state_d = ST_CMD;
            chk_d   = 8'h00;
            len_d   = 5'd0;
            data_d  = '0;
          end
        end
        ST_CMD: begin
          cmd_d   = rx_byte;
          chk_d   = chk_q ^ rx_byte;
          state_d = ST_ADDR;
        end
        ST_ADDR: begin
          addr_d  = rx_byte;
          chk_d   = chk_q ^ rx_byte;
          state_d = ST_LEN;
        end
        ST_LEN: begin
          if (rx_byte > MAX_LEN_B) begin
            // Rest of the oversize frame is treated as noise by the SOF hunt.
            err_d   = 1'b1;
            code_d  = 2'd2;
            state_d = ST_SOF;
          end else begin
            len_d   = rx_byte[4:0];
            chk_d   = chk_q ^ rx_byte;
            idx_d   = '0;
            state_d = (rx_byte == 8'h00) ? ST_CHK : ST_DATA;
          end
        end
        ST_DATA: begin
          data_d[8*int'(idx_q) +: 8] = rx_byte;
          chk_d = chk_q ^ rx_byte;
          idx_d = idx_q + 1'b1;
          if (5'(idx_q) == (len_q - 5'd1)) state_d = ST_CHK;
        end
        ST_CHK: begin
          if (rx_byte == chk_q) begin
            valid_d = 1'b1;
            state_d = ST_OUT;
          end else begin
            err_d   = 1'b1;
            code_d  = 2'd1;
            state_d = ST_SOF;
          end
        end
        default: state_d = ST_SOF;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_SOF;
      byte_vld_q <= 1'b0;
      chk_q      <= 8'h00;
      idx_q      <= '0;
      tmo_q      <= '0;
      cmd_q      <= 8'h00;
      addr_q     <= 8'h00;
      len_q      <= 5'd0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      code_q     <= 2'd0;
    end else begin
      state_q    <= state_d;
      byte_vld_q <= rd_en;
      chk_q      <= chk_d;
      idx_q      <= idx_d;
      tmo_q      <= tmo_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      code_q     <= code_d;
    end
  end
endmodule

// File: tb/tb_host_rx_frame_parser.sv
// Bench for host_rx_frame_parser: a queue-based RX FIFO model, a monitor that
// records every dropped-frame report and every accepted frame, and per-scenario
// tasks that compare the recorded events against expectations built from the
// frame format.
module tb_host_rx_frame_parser;
  localparam int MAX_LEN = 4;
  localparam int TMO     = 64;
  localparam int EW      = 56;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] dbg_state;
  logic [2:0] idle_state;

  host_rx_frame_if #(.MAX_LEN(MAX_LEN)) bus ();

  host_rx_frame_parser #(
    .SOF_BYTE(8'hA5), .MAX_LEN(MAX_LEN), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]    fq[$];
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] obs_q[$];

  int cyc = 0;
  int last_rd_cyc = 0;
  int last_err_cyc = 0;
  int err_seen = 0;
  int accepts = 0;
  int stall_viol = 0;
  int both_viol = 0;

  // FIFO model: pop on rd_en, data appears the next cycle.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.fifo_rd_en) begin
      if (fq.size() > 0) bus.fifo_dout <= fq.pop_front();
      else bus.fifo_dout <= 8'h00;
    end
  end

  always @(negedge clk) begin
    #1;
    bus.fifo_empty = (fq.size() == 0);
  end

  // Monitor: runs after the drivers and the FIFO flag update.
  always @(negedge clk) begin
    #2;
    if (reset_n) begin
      if (bus.fifo_rd_en) begin
        last_rd_cyc = cyc;
        if (bus.frm_valid) stall_viol++;
      end
      if (bus.frm_err && bus.frm_valid) both_viol++;
      if (bus.frm_err) begin
        last_err_cyc = cyc;
        err_seen++;
        obs_q.push_back({1'b1, bus.frm_err_code, 50'd0});
      end
      if (bus.frm_valid && bus.frm_ready) begin
        accepts++;
        obs_q.push_back({1'b0, 2'b00, bus.frm_cmd, bus.frm_addr, bus.frm_len, bus.frm_data});
      end
    end
  end

  function automatic logic [EW-1:0] ev_ok(input logic [7:0] c, input logic [7:0] a,
                                          input int l, input logic [31:0] d);
    logic [31:0] m;
    m = 32'd0;
    for (int i = 0; i < l; i++) m[8*i +: 8] = d[8*i +: 8];
    return {1'b0, 2'b00, c, a, 5'(l), m};
  endfunction

  function automatic logic [EW-1:0] ev_err(input logic [1:0] code);
    return {1'b1, code, 50'd0};
  endfunction

  // Queue one complete frame; a nonzero flip corrupts the checksum byte.
  task automatic send_frame(input logic [7:0] c, input logic [7:0] a, input int l,
                            input logic [31:0] d, input logic [7:0] flip);
    logic [7:0] chk;
    chk = c ^ a ^ 8'(l);
    fq.push_back(8'hA5);
    fq.push_back(c);
    fq.push_back(a);
    fq.push_back(8'(l));
    for (int i = 0; i < l; i++) begin
      fq.push_back(d[8*i +: 8]);
      chk = chk ^ d[8*i +: 8];
    end
    fq.push_back(chk ^ flip);
    if (flip == 8'h00) exp_q.push_back(ev_ok(c, a, l, d));
    else exp_q.push_back(ev_err(2'd1));
  endtask

  task automatic wait_done(input int lim);
    int n;
    n = 0;
    while (((obs_q.size() < exp_q.size()) || (fq.size() != 0)) && (n < lim)) begin
      @(negedge clk); #3;
      n++;
    end
    repeat (4) @(negedge clk);
    #3;
  endtask

  task automatic test_reset;
    fq.push_back(8'h77);
    repeat (3) @(negedge clk);
    #3;
    checks++;
    if (bus.fifo_rd_en !== 1'b0) begin errors++; $display("FAIL rst_rd_en got=%b exp=0", bus.fifo_rd_en); end
    checks++;
    if (bus.frm_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", bus.frm_valid); end
    checks++;
    if (bus.frm_err !== 1'b0) begin errors++; $display("FAIL rst_err got=%b exp=0", bus.frm_err); end
    checks++;
    if ({bus.frm_cmd, bus.frm_addr, bus.frm_len, bus.frm_data, bus.frm_err_code} !== 55'd0) begin
      errors++;
      $display("FAIL rst_fields got=%h %h %h %h %h exp=0", bus.frm_cmd, bus.frm_addr, bus.frm_len,
               bus.frm_data, bus.frm_err_code);
    end
    idle_state = dbg_state;
    @(negedge clk);
    reset_n = 1'b1;
    wait_done(100);
    checks++;
    if (fq.size() != 0) begin errors++; $display("FAIL rst_noise_pop got=%0d exp=0 bytes left", fq.size()); end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL rst_noise_event got=%0d exp=0", obs_q.size()); end
    checks++;
    if (dbg_state !== idle_state) begin errors++; $display("FAIL rst_idle got=%0d exp=%0d", dbg_state, idle_state); end
  endtask

  task automatic test_basic;
    int n, held, a0;
    logic [EW-1:0] ev_o, ev_e;
    a0 = accepts;
    bus.frm_ready = 1'b0;
    @(negedge clk);
    send_frame(8'h10, 8'h20, 2, 32'h0000_2211, 8'h00);
    n = 0;
    while (!bus.frm_valid && n < 100) begin @(negedge clk); #3; n++; end
    checks++;
    if (bus.frm_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b exp=1", bus.frm_valid); end
    checks++;
    if ({bus.frm_cmd, bus.frm_addr, bus.frm_len, bus.frm_data} !== {8'h10, 8'h20, 5'd2, 32'h0000_2211}) begin
      errors++;
      $display("FAIL basic_fields got=%h %h %0d %h exp=10 20 2 00002211",
               bus.frm_cmd, bus.frm_addr, bus.frm_len, bus.frm_data);
    end
    held = 0;
    repeat (5) begin
      @(negedge clk); #3;
      if (bus.frm_valid && !bus.fifo_rd_en && bus.frm_data == 32'h0000_2211 && bus.frm_cmd == 8'h10) held++;
    end
    checks++;
    if (held != 5) begin errors++; $display("FAIL basic_hold got=%0d exp=5 cycles", held); end
    @(negedge clk);
    bus.frm_ready = 1'b1;
    @(negedge clk);
    bus.frm_ready = 1'b0;
    #3;
    checks++;
    if (bus.frm_valid !== 1'b0) begin errors++; $display("FAIL basic_drop_valid got=%b exp=0", bus.frm_valid); end
    checks++;
    if (accepts != a0 + 1) begin errors++; $display("FAIL basic_accepts got=%0d exp=%0d", accepts, a0 + 1); end
    while (obs_q.size() > 0) begin
      ev_o = obs_q.pop_front();
      if (exp_q.size() > 0) ev_e = exp_q.pop_front(); else ev_e = '1;
      checks++;
      if (ev_o !== ev_e) begin errors++; $display("FAIL basic_event got=%h exp=%h", ev_o, ev_e); end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL basic_missing got=0 exp=%0d events", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_noise_zero_len;
    int e0;
    logic [EW-1:0] ev_o, ev_e;
    e0 = err_seen;
    bus.frm_ready = 1'b1;
    @(negedge clk);
    fq.push_back(8'h00);
    fq.push_back(8'hFF);
    fq.push_back(8'h5A);
    send_frame(8'h01, 8'h02, 0, 32'h0, 8'h00);
    wait_done(300);
    checks++;
    if (err_seen != e0) begin errors++; $display("FAIL noise_err got=%0d exp=%0d", err_seen, e0); end
    while (obs_q.size() > 0) begin
      ev_o = obs_q.pop_front();
      if (exp_q.size() > 0) ev_e = exp_q.pop_front(); else ev_e = '1;
      checks++;
      if (ev_o !== ev_e) begin errors++; $display("FAIL noise_event got=%h exp=%h", ev_o, ev_e); end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL noise_missing got=0 exp=%0d events", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_bad_chk;
    int e0;
    logic [EW-1:0] ev_o, ev_e;
    e0 = err_seen;
    bus.frm_ready = 1'b1;
    @(negedge clk);
    send_frame(8'h01, 8'h02, 1, 32'h33, 8'h31);
    send_frame(8'h5C, 8'hA5, 3, 32'h00A5_1234, 8'h00);
    wait_done(300);
    checks++;
    if (err_seen != e0 + 1) begin errors++; $display("FAIL chk_err_count got=%0d exp=%0d", err_seen, e0 + 1); end
    while (obs_q.size() > 0) begin
      ev_o = obs_q.pop_front();
      if (exp_q.size() > 0) ev_e = exp_q.pop_front(); else ev_e = '1;
      checks++;
      if (ev_o !== ev_e) begin errors++; $display("FAIL chk_event got=%h exp=%h", ev_o, ev_e); end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL chk_missing got=0 exp=%0d events", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_bad_len;
    int e0, n;
    logic [EW-1:0] ev_o, ev_e;
    e0 = err_seen;
    bus.frm_ready = 1'b1;
    @(negedge clk);
    fq.push_back(8'hA5);
    fq.push_back(8'h01);
    fq.push_back(8'h02);
    fq.push_back(8'h05);
    exp_q.push_back(ev_err(2'd2));
    n = 0;
    while (err_seen == e0 && n < 100) begin @(negedge clk); #3; n++; end
    checks++;
    if (last_err_cyc - last_rd_cyc != 2) begin
      errors++;
      $display("FAIL len_latency got=%0d exp=2 cycles after LEN pop", last_err_cyc - last_rd_cyc);
    end
    send_frame(8'h01, 8'h02, 4, 32'hDEAD_BEEF, 8'h00);
    wait_done(300);
    while (obs_q.size() > 0) begin
      ev_o = obs_q.pop_front();
      if (exp_q.size() > 0) ev_e = exp_q.pop_front(); else ev_e = '1;
      checks++;
      if (ev_o !== ev_e) begin errors++; $display("FAIL len_event got=%h exp=%h", ev_o, ev_e); end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL len_missing got=0 exp=%0d events", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_timeout;
    int e0, n;
    logic [EW-1:0] ev_o, ev_e;
    e0 = err_seen;
    bus.frm_ready = 1'b1;
    @(negedge clk);
    fq.push_back(8'hA5);
    fq.push_back(8'h01);
    exp_q.push_back(ev_err(2'd3));
    n = 0;
    while (err_seen == e0 && n < TMO + 50) begin @(negedge clk); #3; n++; end
    checks++;
    if (last_err_cyc - last_rd_cyc != TMO + 2) begin
      errors++;
      $display("FAIL tmo_latency got=%0d exp=%0d cycles after last pop", last_err_cyc - last_rd_cyc, TMO + 2);
    end
    @(negedge clk); #3;
    checks++;
    if (bus.frm_err !== 1'b0) begin errors++; $display("FAIL tmo_pulse got=%b exp=0", bus.frm_err); end
    checks++;
    if (dbg_state !== idle_state) begin errors++; $display("FAIL tmo_idle got=%0d exp=%0d", dbg_state, idle_state); end
    while (obs_q.size() > 0) begin
      ev_o = obs_q.pop_front();
      if (exp_q.size() > 0) ev_e = exp_q.pop_front(); else ev_e = '1;
      checks++;
      if (ev_o !== ev_e) begin errors++; $display("FAIL tmo_event got=%h exp=%h", ev_o, ev_e); end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL tmo_missing got=0 exp=%0d events", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_back_to_back;
    int a0, e0, s0, n;
    logic [EW-1:0] ev_o, ev_e;
    a0 = accepts;
    s0 = stall_viol;
    bus.frm_ready = 1'b0;
    @(negedge clk);
    send_frame(8'h11, 8'h22, 3, 32'h00CC_BBAA, 8'h00);
    send_frame(8'h33, 8'h44, 1, 32'h0000_00DD, 8'h00);
    repeat (50) @(negedge clk);
    #3;
    checks++;
    if (fq.size() != 6) begin errors++; $display("FAIL b2b_stall_bytes got=%0d exp=6", fq.size()); end
    checks++;
    if (!(bus.frm_valid === 1'b1 && bus.frm_cmd === 8'h11)) begin
      errors++;
      $display("FAIL b2b_first got=valid %b cmd %h exp=valid 1 cmd 11", bus.frm_valid, bus.frm_cmd);
    end
    checks++;
    if (stall_viol != s0) begin errors++; $display("FAIL b2b_pop_in_stall got=%0d exp=%0d", stall_viol, s0); end
    @(negedge clk);
    bus.frm_ready = 1'b1;
    wait_done(300);
    checks++;
    if (accepts != a0 + 2) begin errors++; $display("FAIL b2b_accepts got=%0d exp=%0d", accepts, a0 + 2); end
    while (obs_q.size() > 0) begin
      ev_o = obs_q.pop_front();
      if (exp_q.size() > 0) ev_e = exp_q.pop_front(); else ev_e = '1;
      checks++;
      if (ev_o !== ev_e) begin errors++; $display("FAIL b2b_event got=%h exp=%h", ev_o, ev_e); end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_missing got=0 exp=%0d events", exp_q.size()); exp_q.delete(); end

    // Reset while the parser waits for the third payload byte.
    e0 = err_seen;
    fq.push_back(8'hA5);
    fq.push_back(8'h01);
    fq.push_back(8'h02);
    fq.push_back(8'h03);
    fq.push_back(8'h11);
    fq.push_back(8'h22);
    n = 0;
    while (fq.size() != 0 && n < 100) begin @(negedge clk); n++; end
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    #3;
    checks++;
    if ({bus.frm_valid, bus.frm_err, bus.fifo_rd_en} !== 3'b000) begin
      errors++;
      $display("FAIL midrst_ctrl got=%b exp=000", {bus.frm_valid, bus.frm_err, bus.fifo_rd_en});
    end
    checks++;
    if ({bus.frm_cmd, bus.frm_addr, bus.frm_len, bus.frm_data, bus.frm_err_code} !== 55'd0) begin
      errors++;
      $display("FAIL midrst_fields got=%h %h %h %h exp=0", bus.frm_cmd, bus.frm_addr, bus.frm_len, bus.frm_data);
    end
    checks++;
    if (dbg_state !== idle_state) begin errors++; $display("FAIL midrst_idle got=%0d exp=%0d", dbg_state, idle_state); end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (TMO + 20) @(negedge clk);
    #3;
    checks++;
    if (err_seen != e0) begin errors++; $display("FAIL midrst_err got=%0d exp=%0d", err_seen, e0); end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL midrst_event got=%0d exp=0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_random;
    int kind, len, n, nn;
    logic [7:0] c, a, b;
    logic [31:0] d;
    logic [EW-1:0] ev_o, ev_e;
    @(negedge clk);
    for (int f = 0; f < 30; f++) begin
      kind = $urandom_range(0, 9);
      c = 8'($urandom);
      a = 8'($urandom);
      d = $urandom;
      if (kind <= 5) begin
        send_frame(c, a, $urandom_range(0, MAX_LEN), d, 8'h00);
      end else if (kind <= 7) begin
        send_frame(c, a, $urandom_range(0, MAX_LEN), d, 8'($urandom_range(1, 255)));
      end else if (kind == 8) begin
        len = $urandom_range(MAX_LEN + 1, 255);
        fq.push_back(8'hA5);
        fq.push_back(c);
        fq.push_back(a);
        fq.push_back(8'(len));
        exp_q.push_back(ev_err(2'd2));
      end else begin
        nn = $urandom_range(1, 3);
        for (int k = 0; k < nn; k++) begin
          b = 8'($urandom);
          if (b == 8'hA5) b = 8'h00;
          fq.push_back(b);
        end
      end
    end
    n = 0;
    while (((obs_q.size() < exp_q.size()) || (fq.size() != 0)) && n < 20000) begin
      @(negedge clk);
      bus.frm_ready = 1'($urandom_range(0, 1));
      n++;
    end
    @(negedge clk);
    bus.frm_ready = 1'b1;
    repeat (4) @(negedge clk);
    #3;
    while (obs_q.size() > 0) begin
      ev_o = obs_q.pop_front();
      if (exp_q.size() > 0) ev_e = exp_q.pop_front(); else ev_e = '1;
      checks++;
      if (ev_o !== ev_e) begin errors++; $display("FAIL rand_event got=%h exp=%h", ev_o, ev_e); end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rand_missing got=0 exp=%0d events", exp_q.size()); exp_q.delete(); end
  endtask

  initial begin
    reset_n = 1'b0;
    bus.frm_ready = 1'b0;
    test_reset;
    test_basic;
    test_noise_zero_len;
    test_bad_chk;
    test_bad_len;
    test_timeout;
    test_back_to_back;
    test_random;
    checks++;
    if (stall_viol != 0) begin errors++; $display("FAIL pop_while_valid got=%0d exp=0", stall_viol); end
    checks++;
    if (both_viol != 0) begin errors++; $display("FAIL err_and_valid got=%0d exp=0", both_viol); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
